// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//
// Executes MULT/MULTU/DIV/DIVU as one radix-2 step per cycle over WIDTH
// cycles, then applies sign correction in a single FIXUP cycle and writes
// HI/LO. MTHI/MTLO/MFHI/MFLO complete in one cycle from IDLE.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   in_valid/in_ready request handshake (see below)
//   func              6-bit R-type function code
//   src_a, src_b      rs / rt operands
//   flush             abort in-flight op, drop any request this cycle
//   busy              multiply/divide in flight (RUN or FIXUP)
//   out_valid         out_data holds an MFHI/MFLO result (one cycle)
//   out_data          move-from result, held while out_valid is low
//   hi, lo            architectural HI/LO registers
//   dbg_state         current FSM state for observation
//
// Handshake: a request transfers on a rising edge where in_valid=1,
// in_ready=1, flush=0 and func is a legal code; in_ready depends on state
// only, so the requester may hold in_valid and its payload until it sees
// in_ready. Illegal codes are never accepted and cause no state change.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int DIV_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t state, state_next;

    // Datapath state. acc holds {upper, lower} halves: for multiply the
    // partial product shifts right through it; for divide the upper half
    // is the partial remainder and the lower half shifts in quotient bits.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   save_a;    // raw dividend for divide-by-zero result
    logic [WIDTH-1:0]   cnt;
    logic               op_div;
    logic               neg_q;     // negate product / quotient
    logic               neg_r;     // negate remainder (dividend sign)
    logic               div_zero;

    // ---------------- decode ----------------
    logic dec_mul, dec_div, dec_move, legal, accept, start, signed_op;

    always_comb begin
        dec_mul   = (func == FN_MULT) || (func == FN_MULTU);
        dec_div   = (DIV_EN != 0) && ((func == FN_DIV) || (func == FN_DIVU));
        dec_move  = (func == FN_MFHI) || (func == FN_MTHI) ||
                    (func == FN_MFLO) || (func == FN_MTLO);
        legal     = dec_mul || dec_div || dec_move;
        accept    = in_valid && (state == S_IDLE) && !flush && legal;
        start     = accept && (dec_mul || dec_div);
        // Signed variants have func[0] clear.
        signed_op = !func[0];
    end

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic             sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_next = S_FIXUP;
            S_FIXUP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // ---------------- iteration step ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        // The partial remainder stays below the divisor, so a clear top bit
        // of the difference means the trial subtraction did not borrow.
        div_ge    = !div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
    end

    // ---------------- sign fixup ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (op_div) begin
            fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            if (div_zero) begin
                fix_lo = {WIDTH{1'b1}};
                fix_hi = save_a;
            end
        end
    end

    // ---------------- datapath / architectural registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            save_a    <= '0;
            op_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                case (func)
                    FN_MTHI: hi <= src_a;
                    FN_MTLO: lo <= src_a;
                    FN_MFHI: begin
                        out_data  <= hi;
                        out_valid <= 1'b1;
                    end
                    FN_MFLO: begin
                        out_data  <= lo;
                        out_valid <= 1'b1;
                    end
                    default: ;
                endcase
                if (start) begin
                    cnt      <= '0;
                    op_div   <= dec_div;
                    neg_q    <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    neg_r    <= signed_op && src_a[WIDTH-1];
                    div_zero <= dec_div && (src_b == '0);
                    save_a   <= src_a;
                    acc      <= {{WIDTH{1'b0}}, mag(src_a, signed_op)};
                    opnd     <= mag(src_b, signed_op);
                end
            end else if ((state == S_RUN) && !flush) begin
                cnt <= cnt + WIDTH'(1);
                acc <= op_div ? div_next : mul_next;
            end else if ((state == S_FIXUP) && !flush) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit: directed + random checks of muldiv_unit at WIDTH=32.
// Expected HI/LO and move-from results are pushed to exp_q when a request
// is driven and popped when the unit completes it.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   func;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    muldiv_unit #(.WIDTH(W), .DIV_EN(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Reference model used for the random operations.
    function automatic void model(input logic [5:0] f, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        longint      sa, sb, p, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = '0;
        el = '0;
        case (f)
            FN_MULT: begin
                p  = sa * sb;
                u  = p;
                eh = u[63:32];
                el = u[31:0];
            end
            FN_MULTU: begin
                u  = {32'b0, a} * {32'b0, b};
                eh = u[63:32];
                el = u[31:0];
            end
            FN_DIV: begin
                if (b == '0) begin
                    el = '1;
                    eh = a;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            default: begin
                if (b == '0) begin
                    el = '1;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // ---------------- driver tasks (called and return at a negedge) -------
    task automatic drive_req(input logic [5:0] f, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        in_valid = 1'b1;
        func     = f;
        src_a    = a;
        src_b    = b;
        @(negedge clk);
        in_valid = 1'b0;
        func     = 6'b000000;
    endtask

    task automatic run_op(input string tag, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        int cycles;
        exp_q.push_back(eh);
        exp_q.push_back(el);
        drive_req(f, a, b);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, W'(cycles), W'(W + 1));
        pop_check({tag, "_hi"}, hi);
        pop_check({tag, "_lo"}, lo);
    endtask

    task automatic mf_req(input string tag, input logic [5:0] f,
                          input logic [W-1:0] e);
        int waited;
        exp_q.push_back(e);
        drive_req(f, '0, '0);
        waited = 0;
        while (!out_valid && waited < 8) begin
            waited++;
            @(negedge clk);
        end
        check({tag, "_valid"}, W'(out_valid), W'(1));
        check({tag, "_wait"}, W'(waited), W'(0));
        pop_check({tag, "_data"}, out_data);
        @(negedge clk);
        check({tag, "_valid_drop"}, W'(out_valid), W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0]   rf;
        logic [W-1:0] ra, rb, reh, rel;
        int           wd;

        reset    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        func     = 6'b000000;
        src_a    = '0;
        src_b    = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_busy", W'(busy), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_state", W'(dbg_state), W'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Signed multiply, then MFLO in the cycle right after FIXUP.
        run_op("mult_neg", FN_MULT, 32'hFFFFFFFD, 32'h00000005,
               32'hFFFFFFFF, 32'hFFFFFFF1);
        mf_req("mflo_after_mult", FN_MFLO, 32'hFFFFFFF1);

        run_op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg", FN_DIV, 32'hFFFFFFF9, 32'h00000002,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", FN_DIVU, 32'h00000007, 32'h00000000,
               32'h00000007, 32'hFFFFFFFF);
        run_op("div_ovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000);

        // MTHI, then a MULT flushed on its 10th RUN cycle.
        drive_req(FN_MTHI, 32'h12345678, '0);
        check("mthi_hi", hi, 32'h12345678);
        drive_req(FN_MULT, 32'h00000003, 32'h00000007);
        repeat (9) @(negedge clk);
        check("flush_pre_busy", W'(busy), W'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", W'(busy), W'(0));
        check("flush_in_ready", W'(in_ready), W'(1));
        check("flush_hi", hi, 32'h12345678);
        check("flush_lo", lo, 32'h80000000);
        mf_req("mfhi_after_flush", FN_MFHI, 32'h12345678);

        // Back-to-back move-to then move-from.
        drive_req(FN_MTLO, 32'hA5A5A5A5, '0);
        mf_req("b2b_lo", FN_MFLO, 32'hA5A5A5A5);
        drive_req(FN_MTHI, 32'h0BADF00D, '0);
        mf_req("b2b_hi", FN_MFHI, 32'h0BADF00D);

        // Illegal code: no acceptance, no state change.
        drive_req(6'b100000, 32'hDEADBEEF, 32'h1);
        check("illegal_busy", W'(busy), W'(0));
        check("illegal_out_valid", W'(out_valid), W'(0));
        check("illegal_hi", hi, 32'h0BADF00D);
        check("illegal_lo", lo, 32'hA5A5A5A5);

        // Flush wins over a simultaneous request.
        flush = 1'b1;
        drive_req(FN_MFHI, '0, '0);
        check("flush_mf_out_valid", W'(out_valid), W'(0));
        drive_req(FN_MTHI, 32'h11111111, '0);
        flush = 1'b0;
        check("flush_mthi_hi", hi, 32'h0BADF00D);
        drive_req(FN_MULTU, 32'h2, 32'h2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run1_busy", W'(busy), W'(0));

        // Random operations against the reference model.
        for (int i = 0; i < 6; i++) begin
            rf = FN_MULT | 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
            model(rf, ra, rb, reh, rel);
            run_op("rand", rf, ra, rb, reh, rel);
        end

        // Asynchronous reset in the middle of a divide.
        drive_req(FN_DIV, 32'h00001234, 32'h00000011);
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("multu_after_rst", FN_MULTU, 32'h2, 32'h3, 32'h0, 32'h6);

        wd = exp_q.size();
        check("queue_drained", W'(wd), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are even and at least 4.
REQ-002 SHALL have parameter DIV_EN, default 1; when 0, DIV and DIVU are treated as illegal codes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: request present.
REQ-006 SHALL have port in_ready, output, 1 bit: unit accepts a request this cycle.
REQ-007 SHALL have port func, input, 6 bits: R-type function code of the request.
REQ-008 SHALL have port src_a, input, WIDTH bits: rs operand.
REQ-009 SHALL have port src_b, input, WIDTH bits: rt operand.
REQ-010 SHALL have port flush, input, 1 bit: abort the in-flight operation and drop any request this cycle.
REQ-011 SHALL have port busy, output, 1 bit: a multiply or divide is in flight.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data holds an MFHI/MFLO result.
REQ-013 SHALL have port out_data, output, WIDTH bits: move-from result.
REQ-014 SHALL have ports hi and lo, outputs, WIDTH bits each: architectural HI and LO registers.

Function
REQ-015 SHALL decode these func codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
REQ-016 SHALL ignore any other func code: not accepted, no state change.
REQ-017 SHALL accept a request on a rising edge where in_valid=1, in_ready=1, flush=0 and func is legal.
REQ-018 SHALL drive in_ready = (state==IDLE); in_ready is combinational from state only.
REQ-019 SHALL implement states IDLE, RUN, FIXUP.
- IDLE->RUN on acceptance of MULT, MULTU, DIV or DIVU.
- RUN->FIXUP after exactly WIDTH RUN cycles.
- FIXUP->IDLE unconditionally.
REQ-020 SHALL in RUN perform one radix-2 step per cycle on magnitudes.
- Multiply: shift-add over a 2*WIDTH product.
- Divide: restoring divide producing a WIDTH quotient and a WIDTH remainder.
- A WIDTH-bit cycle counter tracks the steps.
REQ-021 SHALL in FIXUP apply sign correction for MULT/DIV and write HI/LO on the FIXUP->IDLE edge.
- Multiply: HI = upper half, LO = lower half.
- Divide: LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
- Total latency from acceptance edge to HI/LO update is WIDTH+1 cycles.
REQ-022 SHALL assert busy in RUN and FIXUP only.
REQ-023 SHALL handle divide-by-zero (src_b=0): LO = all ones, HI = src_a, with the normal WIDTH+1 latency.
REQ-024 SHALL handle signed overflow (DIV with src_a = most-negative, src_b = all ones): LO = most-negative, HI = 0.
REQ-025 SHALL for MTHI/MTLO update hi/lo on the acceptance edge, stay in IDLE and not assert out_valid.
REQ-026 SHALL for MFHI/MFLO register the current hi/lo into out_data on the acceptance edge and assert out_valid for exactly one cycle; the unit stays in IDLE.
REQ-027 SHALL allow back-to-back requests: MTHI then MFHI on consecutive cycles returns the new value.
REQ-028 SHALL return the freshly written value for an MF request accepted the cycle after FIXUP.
REQ-029 SHALL on flush in RUN or FIXUP return to IDLE at the next edge with hi/lo unchanged.
REQ-030 SHALL on flush clear out_valid at the next edge; flush has priority over a simultaneous in_valid.
REQ-031 SHALL hold out_data stable when out_valid=0; its value is don't-care but must not be X after reset.

Reset
REQ-032 SHALL on reset assertion, immediately and asynchronously, set state=IDLE, hi=0, lo=0, out_valid=0, out_data=0, counter=0.
REQ-033 SHALL make in_ready rise to 1 once state=IDLE, and busy fall to 0, immediately on reset assertion.
REQ-034 SHALL abort any in-flight operation on reset mid-operation, with no partial HI/LO write.

Verification (WIDTH=32)
REQ-035 SHALL cover MULT FFFFFFFD x 00000005 -> busy for 33 cycles, then HI=FFFFFFFF, LO=FFFFFFF1; a following MFLO gives out_valid one cycle later with out_data=FFFFFFF1.
REQ-036 SHALL cover MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
REQ-037 SHALL cover DIV FFFFFFF9 / 00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; then DIVU 00000007 / 0 -> LO=FFFFFFFF, HI=00000007.
REQ-038 SHALL cover DIV 80000000 / FFFFFFFF -> LO=80000000, HI=00000000, with no hang.
REQ-039 SHALL cover MTHI 12345678 with flush held low, then a MULT flushed on its 10th RUN cycle -> busy=0 next edge, HI=12345678, in_ready=1, a subsequent MFHI returns 12345678.
REQ-040 SHALL cover reset asserted mid-edge during a DIV -> hi=lo=0, busy=0, out_valid=0 with no clock edge needed; after deassertion, MULTU 2x3 gives LO=6 after 33 cycles.
